stage2_conv1_conv3_max3x3_in4_out12: RTL and testbench
======================================================

Name: stage2_conv1_conv3_max3x3_in4_out12

Overview:
Streaming inception-style CNN stage with 4 input channels and 12 output channels.
- Out_0..3: 1x1 pointwise conv branch.
- Out_4..7: 3x3 depthwise conv branch.
- Out_8..11: 3x3 max-pool branch.

Pixels arrive in raster order, one per valid beat, all 4 channels in parallel. Each output is computed from a "valid" (unpadded) 3x3 window, and the three branches are aligned to the same window.

Parameters:
- IMG_Width, 4, frame width in pixels (>=3).
- IMG_Height, 4, frame height in pixels (>=3).
- Datawidth, 32, bits per sample; signed two's complement.
- Stride, 1, output decimation in both axes (>=1).
- ReLU, 0, 1 = clamp negative conv results (Out_0..7) to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  input beat valid.
- In_0..In_3  in  Datawidth each  channel 0..3 sample of the current pixel.
- valid_out  out  1  output beat valid.
- Out_0..Out_3  out  Datawidth each  1x1 conv result, channels 0..3.
- Out_4..Out_7  out  Datawidth each  3x3 depthwise conv result of In_0..In_3.
- Out_8..Out_11  out  Datawidth each  3x3 max of In_0..In_3.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset clears valid_out, all Out_*, and the row/column counters to 0. Line-buffer contents need not be cleared.
- Accepted beat = valid_in high, rst low. A low valid_in stalls everything: no shift, no counter change.
- Counters:
  - col increments on each accepted beat; at IMG_Width-1 it wraps to 0 and row increments.
  - row wraps at IMG_Height-1, so frames stream back-to-back with no gap.
- Per channel: two IMG_Width-deep line buffers plus a 3x3 window. After accepting pixel (r,c), the window holds rows r-2..r and cols c-2..c. The centre sample is (r-1,c-1).
- Emit condition for pixel (r,c): r>=2, c>=2, (r-2)%Stride==0 and (c-2)%Stride==0.
  - On an emitting beat, valid_out=1 on the next cycle (1-cycle latency), with all 12 outputs registered.
  - Otherwise valid_out=0 and the Out_* registers hold their last values.
- Out_j (j=0..3) = sum over i of W1[j][i]*centre_i.
- Out_4+j = sum over the 9 taps of K3[k]*window_j[k]. k is raster order within the window.
- Out_8+j = signed max over the 9 samples of window_j.
- Arithmetic rules:
  - Products and sums are computed wide, then truncated to Datawidth (wrap, no saturation).
  - ReLU applies after truncation, to Out_0..7 only. The max branch is never clamped.
- Window columns never straddle a row boundary, because the emit condition requires c>=2.
- A reset mid-frame restarts at (0,0). Stale line-buffer data is overwritten before any window uses it.

Decomposition:
- Shared package stage2_pkg:
  - Signed weight constants W1[4][4], default identity.
  - K3[9], default all 1.
  - Helper constant for the window size (9).
- Sub-module stage2_window3x3: one channel's line buffers and 3x3 window. Instantiated 4 times and fed shared shift-enable and counters.
- Top level holds the counters, emit logic, the three branch computations and the output registers.

Test Plan:
- Defaults, In_0..3 all = i for beats i=1..16:
  - First valid_out the cycle after beat 11: Out_0..3=6, Out_4..7=54, Out_8..11=11.
  - Then (7,63,12), (10,90,15), (11,99,16) after beats 12, 15 and 16.
  - Exactly 4 valid pulses per frame.
- Continue i=17..48 (three frames total):
  - Second frame first output: 22/198/27.
  - 12 valid pulses total.
  - Counters wrap correctly with no gap beats.
- Stride=2, 4x4 frame: only one output per frame, after beat 11, with value 6/54/11.
- ReLU=1, all inputs = -1:
  - Out_0..7 = 0.
  - Out_8..11 = -1 (0xFFFFFFFF).
- ReLU=0, all inputs = -1: Out_0..3=-1, Out_4..7=-9.
- Stalls and reset:
  - Toggle valid_in low on alternate cycles: identical output values and order; valid_out only follows accepted beats.
  - Assert rst at beat 7, then restart: all outputs 0, valid_out 0, and the next frame behaves like the first scenario.

Source files
------------

// File: rtl/stage2_conv1_conv3_max3x3_in4_out12_pkg.sv
// Shared constants for the inception-style stage: channel counts, window
// geometry and the fixed weights of the 1x1 and 3x3 convolution branches.
package stage2_pkg;

   localparam int NCH        = 4;   // input channels
   localparam int NOUT       = 12;  // output channels (3 branches x NCH)
   localparam int NWIN       = 9;   // samples in a 3x3 window
   localparam int CENTRE_TAP = 4;   // raster index of the window centre
   localparam int COEF_W     = 32;  // weight word width

   typedef logic signed [COEF_W-1:0] coef_t;

   // Pointwise weights, W1[out][in]; identity by default.
   localparam coef_t W1 [NCH][NCH] = '{
      '{32'sd1, 32'sd0, 32'sd0, 32'sd0},
      '{32'sd0, 32'sd1, 32'sd0, 32'sd0},
      '{32'sd0, 32'sd0, 32'sd1, 32'sd0},
      '{32'sd0, 32'sd0, 32'sd0, 32'sd1}
   };

   // Depthwise 3x3 kernel in raster order, shared by every channel.
   localparam coef_t K3 [NWIN] = '{
      32'sd1, 32'sd1, 32'sd1,
      32'sd1, 32'sd1, 32'sd1,
      32'sd1, 32'sd1, 32'sd1
   };

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stage2_conv1_conv3_max3x3_in4_out12_window3x3.sv
// One channel's two line buffers and 3x3 sliding window. The exported window
// is the one that results from the current beat (combinational look-ahead),
// so the top level can register its results on the same edge.
module stage2_window3x3
   import stage2_pkg::*;
#(
   parameter int DW    = 32,
   parameter int IMG_W = 4
)(
   input  logic                                i_clk,
   input  logic                                i_shift,
   input  logic [min1_clog2(IMG_W)-1:0]        i_col,
   input  logic [DW-1:0]                       i_din,
   output logic [NWIN-1:0][DW-1:0]             o_win
);

   logic [DW-1:0]           r_lb1 [IMG_W];  // previous row, indexed by column
   logic [DW-1:0]           r_lb2 [IMG_W];  // row before that
   logic [DW-1:0]           r_win [NWIN];   // raster order, tap 0 = oldest row/col
   logic [DW-1:0]           w_lb1_rd;
   logic [DW-1:0]           w_lb2_rd;
   logic [NWIN-1:0][DW-1:0] w_next;

   assign w_lb1_rd = r_lb1[i_col];
   assign w_lb2_rd = r_lb2[i_col];

   // Window after this beat: every row shifts left, new column enters on the right.
   always_comb begin
      w_next = '0;
      for (int rr = 0; rr < 3; rr++) begin
         w_next[3*rr]     = r_win[3*rr+1];
         w_next[3*rr + 1] = r_win[3*rr+2];
      end
      w_next[2] = w_lb2_rd;
      w_next[5] = w_lb1_rd;
      w_next[8] = i_din;
   end

   // Line buffers: the column slot moves one row older and takes the new sample.
   always_ff @(posedge i_clk) begin
      if (i_shift) begin
         r_lb1[i_col] <= i_din;
         r_lb2[i_col] <= w_lb1_rd;
      end
   end

   // Window register advances only on accepted beats.
   always_ff @(posedge i_clk) begin
      if (i_shift) begin
         for (int k = 0; k < NWIN; k++) begin
            r_win[k] <= w_next[k];
         end
      end
   end

   assign o_win = w_next;

endmodule

// File: rtl/stage2_conv1_conv3_max3x3_in4_out12.sv
// Streaming inception-style stage: 4 input channels, 12 outputs made of a 1x1
// conv branch, a 3x3 depthwise conv branch and a 3x3 max-pool branch, all
// taken from the same valid (unpadded) window with one cycle of latency.
module stage2_conv1_conv3_max3x3_in4_out12
   import stage2_pkg::*;
#(
   parameter int IMG_Width  = 4,
   parameter int IMG_Height = 4,
   parameter int Datawidth  = 32,
   parameter int Stride     = 1,
   parameter int ReLU       = 0
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [Datawidth-1:0] In_0,
   input  logic [Datawidth-1:0] In_1,
   input  logic [Datawidth-1:0] In_2,
   input  logic [Datawidth-1:0] In_3,
   output logic                 valid_out,
   output logic [Datawidth-1:0] Out_0,
   output logic [Datawidth-1:0] Out_1,
   output logic [Datawidth-1:0] Out_2,
   output logic [Datawidth-1:0] Out_3,
   output logic [Datawidth-1:0] Out_4,
   output logic [Datawidth-1:0] Out_5,
   output logic [Datawidth-1:0] Out_6,
   output logic [Datawidth-1:0] Out_7,
   output logic [Datawidth-1:0] Out_8,
   output logic [Datawidth-1:0] Out_9,
   output logic [Datawidth-1:0] Out_10,
   output logic [Datawidth-1:0] Out_11
);

   localparam int DW    = Datawidth;
   localparam int COL_W = min1_clog2(IMG_Width);
   localparam int ROW_W = min1_clog2(IMG_Height);

   logic [COL_W-1:0]        r_col;
   logic [ROW_W-1:0]        r_row;
   logic                    r_valid;
   logic [DW-1:0]           r_out [NOUT];

   logic                    w_accept;
   logic                    w_emit;
   logic                    w_col_last;
   logic                    w_row_last;
   logic [DW-1:0]           w_in  [NCH];
   logic [NWIN-1:0][DW-1:0] w_win [NCH];
   logic signed [DW-1:0]    w_sum1 [NCH];
   logic signed [DW-1:0]    w_sum3 [NCH];
   logic signed [DW-1:0]    w_max  [NCH];
   logic [DW-1:0]           w_res  [NOUT];

   // Clamp negatives to zero when the ReLU option is on.
   function automatic logic [DW-1:0] relu_clamp(input logic signed [DW-1:0] v);
      if ((ReLU != 0) && v[DW-1]) begin
         return '0;
      end else begin
         return v;
      end
   endfunction

   assign w_in[0] = In_0;
   assign w_in[1] = In_1;
   assign w_in[2] = In_2;
   assign w_in[3] = In_3;

   assign w_accept   = valid_in & ~rst;
   assign w_col_last = (r_col == COL_W'(IMG_Width - 1));
   assign w_row_last = (r_row == ROW_W'(IMG_Height - 1));

   // Emit when the window is fully inside the frame and on the stride grid.
   always_comb begin
      w_emit = 1'b0;
      if (w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2))) begin
         w_emit = (((32'(r_row) - 32'd2) % 32'(Stride)) == 32'd0) &&
                  (((32'(r_col) - 32'd2) % 32'(Stride)) == 32'd0);
      end else begin
         w_emit = 1'b0;
      end
   end

   // Raster position of the incoming pixel; frames run back-to-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (valid_in) begin
         if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
               r_row <= '0;
            end else begin
               r_row <= r_row + ROW_W'(1);
            end
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_win
      stage2_window3x3 #(
         .DW    (DW),
         .IMG_W (IMG_Width)
      ) u_win (
         .i_clk   (clk),
         .i_shift (w_accept),
         .i_col   (r_col),
         .i_din   (w_in[g]),
         .o_win   (w_win[g])
      );
   end

   // Branch arithmetic. Two's complement wrap means the low Datawidth bits of
   // a full-width product/sum equal the same computation done modulo
   // 2**Datawidth, so the accumulators are kept at the output width.
   always_comb begin
      for (int j = 0; j < NCH; j++) begin
         w_sum1[j] = '0;
         w_sum3[j] = '0;
         w_max[j]  = $signed(w_win[j][0]);
      end
      for (int j = 0; j < NCH; j++) begin
         for (int i = 0; i < NCH; i++) begin
            w_sum1[j] = w_sum1[j] + DW'(W1[j][i]) * $signed(w_win[i][CENTRE_TAP]);
         end
         for (int k = 0; k < NWIN; k++) begin
            w_sum3[j] = w_sum3[j] + DW'(K3[k]) * $signed(w_win[j][k]);
            if ($signed(w_win[j][k]) > w_max[j]) begin
               w_max[j] = $signed(w_win[j][k]);
            end else begin
               w_max[j] = w_max[j];
            end
         end
      end
   end

   // Gather the twelve results; ReLU touches only the conv branches.
   always_comb begin
      for (int k = 0; k < NOUT; k++) begin
         w_res[k] = '0;
      end
      for (int j = 0; j < NCH; j++) begin
         w_res[j]           = relu_clamp(w_sum1[j]);
         w_res[NCH + j]     = relu_clamp(w_sum3[j]);
         w_res[2*NCH + j]   = w_max[j];
      end
   end

   // Output registers: load on emitting beats, otherwise hold with valid low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         for (int k = 0; k < NOUT; k++) begin
            r_out[k] <= '0;
         end
      end else if (w_emit) begin
         r_valid <= 1'b1;
         for (int k = 0; k < NOUT; k++) begin
            r_out[k] <= w_res[k];
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign valid_out = r_valid;
   assign Out_0  = r_out[0];
   assign Out_1  = r_out[1];
   assign Out_2  = r_out[2];
   assign Out_3  = r_out[3];
   assign Out_4  = r_out[4];
   assign Out_5  = r_out[5];
   assign Out_6  = r_out[6];
   assign Out_7  = r_out[7];
   assign Out_8  = r_out[8];
   assign Out_9  = r_out[9];
   assign Out_10 = r_out[10];
   assign Out_11 = r_out[11];

endmodule

// File: tb/tb_stage2_conv1_conv3_max3x3_in4_out12.sv
// Directed bench: three instances (defaults, Stride=2, ReLU=1) share one
// stimulus stream; expected outputs come from a small arithmetic model of a
// 4x4 frame with per-channel offsets so channel mix-ups show up.
module tb_stage2_conv1_conv3_max3x3_in4_out12;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [31:0] in_0, in_1, in_2, in_3;

   logic        valid_a, valid_s, valid_r;
   logic [31:0] out_a [12];
   logic [31:0] out_s [12];
   logic [31:0] out_r [12];

   logic [31:0] exp_a [12];
   logic [31:0] exp_s [12];
   logic [31:0] exp_r [12];
   logic        ev_a, ev_s, ev_r;

   int vectors;
   int miscompares;
   int pos;
   int pulses_a;
   int pulses_s;

   stage2_conv1_conv3_max3x3_in4_out12 u_dut_a (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .In_0(in_0), .In_1(in_1), .In_2(in_2), .In_3(in_3),
      .valid_out(valid_a),
      .Out_0(out_a[0]), .Out_1(out_a[1]), .Out_2(out_a[2]), .Out_3(out_a[3]),
      .Out_4(out_a[4]), .Out_5(out_a[5]), .Out_6(out_a[6]), .Out_7(out_a[7]),
      .Out_8(out_a[8]), .Out_9(out_a[9]), .Out_10(out_a[10]), .Out_11(out_a[11])
   );

   stage2_conv1_conv3_max3x3_in4_out12 #(.Stride(2)) u_dut_s (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .In_0(in_0), .In_1(in_1), .In_2(in_2), .In_3(in_3),
      .valid_out(valid_s),
      .Out_0(out_s[0]), .Out_1(out_s[1]), .Out_2(out_s[2]), .Out_3(out_s[3]),
      .Out_4(out_s[4]), .Out_5(out_s[5]), .Out_6(out_s[6]), .Out_7(out_s[7]),
      .Out_8(out_s[8]), .Out_9(out_s[9]), .Out_10(out_s[10]), .Out_11(out_s[11])
   );

   stage2_conv1_conv3_max3x3_in4_out12 #(.ReLU(1)) u_dut_r (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .In_0(in_0), .In_1(in_1), .In_2(in_2), .In_3(in_3),
      .valid_out(valid_r),
      .Out_0(out_r[0]), .Out_1(out_r[1]), .Out_2(out_r[2]), .Out_3(out_r[3]),
      .Out_4(out_r[4]), .Out_5(out_r[5]), .Out_6(out_r[6]), .Out_7(out_r[7]),
      .Out_8(out_r[8]), .Out_9(out_r[9]), .Out_10(out_r[10]), .Out_11(out_r[11])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic check_all(input string phase);
      check_one({phase, " a.valid"}, 32'(valid_a), 32'(ev_a));
      check_one({phase, " s.valid"}, 32'(valid_s), 32'(ev_s));
      check_one({phase, " r.valid"}, 32'(valid_r), 32'(ev_r));
      for (int k = 0; k < 12; k++) begin
         check_one($sformatf("%s a.Out_%0d", phase, k), out_a[k], exp_a[k]);
         check_one($sformatf("%s s.Out_%0d", phase, k), out_s[k], exp_s[k]);
         check_one($sformatf("%s r.Out_%0d", phase, k), out_r[k], exp_r[k]);
      end
   endtask

   // Hold rst for two edges; everything reads back as zero afterwards.
   task automatic reset_dut(input string phase);
      rst      = 1'b1;
      valid_in = 1'b1;
      in_0 = 32'd777; in_1 = 32'd778; in_2 = 32'd779; in_3 = 32'd780;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 12; k++) begin
         exp_a[k] = 32'd0;
         exp_s[k] = 32'd0;
         exp_r[k] = 32'd0;
      end
      ev_a = 1'b0; ev_s = 1'b0; ev_r = 1'b0;
      pos = 0;
      check_all(phase);
      rst      = 1'b0;
      valid_in = 1'b0;
   endtask

   // One clock: channel k carries x + k*ofs. With ramp set, the pixel values
   // rise by one per beat, so a 4-wide frame puts the centre at x-5.
   task automatic step(input string phase, input logic v, input int x, input int ofs, input bit ramp);
      int r, c, xi, ctr;
      valid_in = v;
      in_0 = 32'(x);
      in_1 = 32'(x + ofs);
      in_2 = 32'(x + 2*ofs);
      in_3 = 32'(x + 3*ofs);
      @(posedge clk);
      #1;
      ev_a = 1'b0; ev_s = 1'b0; ev_r = 1'b0;
      if (v) begin
         r = pos / 4;
         c = pos % 4;
         if (r >= 2 && c >= 2) begin
            ev_a = 1'b1;
            ev_r = 1'b1;
            ev_s = (r == 2 && c == 2);
            for (int k = 0; k < 4; k++) begin
               xi  = x + k*ofs;
               ctr = ramp ? xi - 5 : xi;
               exp_a[k]     = 32'(ctr);
               exp_a[4 + k] = 32'(9*ctr);
               exp_a[8 + k] = 32'(xi);
               exp_r[k]     = (ctr < 0) ? 32'd0 : 32'(ctr);
               exp_r[4 + k] = (9*ctr < 0) ? 32'd0 : 32'(9*ctr);
               exp_r[8 + k] = 32'(xi);
               if (ev_s) begin
                  exp_s[k]     = 32'(ctr);
                  exp_s[4 + k] = 32'(9*ctr);
                  exp_s[8 + k] = 32'(xi);
               end
            end
         end
         pos = (pos + 1) % 16;
      end
      if (valid_a) pulses_a++;
      if (valid_s) pulses_s++;
      check_all(phase);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      pulses_a    = 0;
      pulses_s    = 0;
      rst         = 1'b1;
      valid_in    = 1'b0;
      in_0 = 32'd0; in_1 = 32'd0; in_2 = 32'd0; in_3 = 32'd0;

      // Reset state, then three back-to-back ramp frames.
      reset_dut("reset");
      for (int n = 1; n <= 48; n++) begin
         step($sformatf("ramp beat %0d", n), 1'b1, n, 1000, 1'b1);
      end
      check_one("pulses 3 frames default", 32'(pulses_a), 32'd12);
      check_one("pulses 3 frames stride2", 32'(pulses_s), 32'd3);

      // Alternate idle cycles carrying junk data.
      reset_dut("reset before stall");
      pulses_a = 0;
      pulses_s = 0;
      for (int n = 1; n <= 16; n++) begin
         step($sformatf("stall beat %0d", n), 1'b1, n, 1000, 1'b1);
         step($sformatf("stall idle %0d", n), 1'b0, 5555 + n, 1000, 1'b1);
      end
      check_one("pulses stalled frame default", 32'(pulses_a), 32'd4);
      check_one("pulses stalled frame stride2", 32'(pulses_s), 32'd1);

      // Reset in the middle of a frame, then a clean frame.
      for (int n = 1; n <= 7; n++) begin
         step($sformatf("pre-reset beat %0d", n), 1'b1, n, 1000, 1'b1);
      end
      reset_dut("mid-frame reset");
      for (int n = 1; n <= 16; n++) begin
         step($sformatf("post-reset beat %0d", n), 1'b1, n, 1000, 1'b1);
      end

      // All samples -1: wrap-free negatives, ReLU clamps conv branches only.
      reset_dut("reset before negative");
      for (int n = 1; n <= 16; n++) begin
         step($sformatf("neg beat %0d", n), 1'b1, -1, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
